file_word_buffer: RTL and testbench
===================================

# file_word_buffer

Buffers the 32-bit word stream produced by the file-backed word source and hands it to the downstream consumer over a valid/ready handshake. Sits directly downstream of the word source, absorbing rate mismatch in a small show-ahead FIFO. Detects the end-of-stream sentinel word, drains, and signals completion. Keeps a running word count and an optional checksum.

## Interface

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, ≥ 2
- AW, 3, log2(DEPTH)
- EOS_WORD, 32'hFFFF_FFFF, end-of-stream sentinel; consumed, never stored

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins or restarts a stream
- in_word  in  32  upstream data
- in_valid  in  1  upstream word present
- in_ready  out  1  buffer accepts in_word this cycle
- out_word  out  32  FIFO head word (show-ahead)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream takes out_word this cycle
- count  out  AW+1  current FIFO occupancy, 0..DEPTH
- words_total  out  16  data words accepted this stream; saturates at 16'hFFFF
- done  out  1  stream fully drained
- checksum  out  32  mod-2^32 sum of accepted data words (CHECKSUM_EN only)

## Operation

- States: IDLE, STREAM, DRAIN, DONE. Reset → IDLE.
- IDLE: in_ready=0. start → STREAM; words_total and checksum cleared in the same edge.
- STREAM: in_ready = (count != DEPTH). Accept = in_valid & in_ready.
  - Accepted word ≠ EOS_WORD: written at tail, words_total++ (saturating), checksum += word.
  - Accepted word == EOS_WORD: not written, not counted → DRAIN.
- DRAIN: in_ready=0; output side keeps popping. count==0 → DONE.
- DONE: done=1, in_ready=0. start → STREAM (clears words_total/checksum; FIFO already empty).
- start is ignored in STREAM and DRAIN.
- Output side, in every state: out_valid = (count != 0); out_word = head entry; pop = out_valid & out_ready.
- Push and pop in the same cycle: both occur, count unchanged. When full, in_ready=0 even if a pop happens that cycle (no bypass).
- Pointers are AW bits, wrap modulo DEPTH; count is AW+1 bits.
- Reset values: in_ready=0, out_valid=0, out_word=0 (head of cleared storage), count=0, words_total=0, done=0, checksum=0; all storage cleared.
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronously). Buffered words are lost.

## Timing

- Push-to-output latency: 1 cycle. Word accepted at edge N is visible with out_valid=1 after edge N when FIFO was empty.
- in_ready, out_valid, count, done all change only at clock edges (registered state/count); in_ready has no combinational path from out_ready.
- EOS accepted at edge N: state=DRAIN after N; if count==0 after N, done=1 after edge N+1.
- Full throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Configuration

- CHECKSUM_EN defined: checksum port present; 32-bit adder accumulates each accepted data word, wraps mod 2^32, cleared on reset and start.
- CHECKSUM_EN undefined: checksum port and adder absent; all other behaviour identical.

## Test plan

- Reset then start, push 3'h words 1,2,3 then EOS with out_ready=1 → out_word sequence 1,2,3; words_total=3; checksum=6; done=1 one cycle after last pop.
- out_ready=0, push 10 words (DEPTH=8) → in_ready drops after 8 accepted, count=8; raise out_ready → remaining 2 accepted, order preserved.
- Full FIFO, in_valid=1 and out_ready=1 same cycle → pop occurs, no push that cycle, count=7; push next cycle.
- Push 32'hFFFF_FFFF first after start → nothing stored, words_total=0, done=1 two edges later; second start restarts with cleared counters.
- Assert rst_n=0 mid-stream with count=5 → count=0, out_valid=0, done=0, state IDLE without waiting for a clock edge; start ignored while in STREAM/DRAIN.
- Push 0xFFFF_FFF0 and 0x20 → checksum=0x0000_0010 (wrap) with CHECKSUM_EN; build without macro passes all other scenarios.

Source files
------------

// File: rtl/file_word_buffer.sv
// file_word_buffer: show-ahead FIFO that sits between the file-backed word
// source and its consumer. It strips the end-of-stream sentinel, drains the
// words still buffered, then raises done. It also keeps a saturating count
// of data words accepted in the current stream.
// Optional feature macro: CHECKSUM_EN adds a mod-2^32 running sum of the
// accepted data words on the checksum port.
module file_word_buffer #(
  parameter int          DEPTH    = 8,
  parameter int          AW       = 3,
  parameter logic [31:0] EOS_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   in_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [15:0]   words_total,
  output logic          done
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          is_eos;
  logic          push;
  logic          pop;
  logic          restart;

  // Handshake and control decodes. Everything here comes from registered
  // state and count, so in_ready has no path from out_ready. A full FIFO
  // refuses input even when a pop happens in the same cycle.
  assign in_ready  = (state == S_STREAM) && (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_word  = mem[rd_ptr];
  assign done      = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign is_eos    = (in_word == EOS_WORD);
  assign push      = accept && !is_eos;
  assign pop       = out_valid && out_ready;
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE));

  // Stream control: the sentinel moves STREAM to DRAIN, and an empty FIFO
  // in DRAIN finishes the stream. start is honoured only in IDLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_STREAM;
        S_STREAM: if (accept && is_eos) state <= S_DRAIN;
        S_DRAIN:  if (count == '0) state <= S_DONE;
        S_DONE:   if (start) state <= S_STREAM;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Storage: each entry is written only when it is the tail of a push.
  // All entries are cleared on reset, so the head reads as zero after reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (push && (wr_ptr == AW'(gi))) begin
        mem[gi] <= in_word;
      end
    end
  end

  // Pointers wrap modulo DEPTH. Occupancy is unchanged when a push and a
  // pop happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-stream data word counter. It saturates instead of wrapping and is
  // cleared when a new stream starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_total <= '0;
    end else if (restart) begin
      words_total <= '0;
    end else if (push && (words_total != 16'hFFFF)) begin
      words_total <= words_total + 16'd1;
    end
  end

`ifdef CHECKSUM_EN
  // Running mod-2^32 sum of the data words accepted in the current stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (restart) begin
      checksum <= '0;
    end else if (push) begin
      checksum <= checksum + in_word;
    end
  end
`endif

endmodule

// File: tb/tb_file_word_buffer.sv
// Testbench for file_word_buffer. A table of directed vectors covers the
// basic stream, a sentinel-only stream, the full-FIFO behaviour and the
// drain. Hand-written sequences cover the asynchronous reset, start being
// ignored mid-stream, and (with CHECKSUM_EN) the checksum.
module tb_file_word_buffer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic [15:0] words_total;
  logic        done;
`ifdef CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int passes = 0;

  localparam logic [31:0] EOS = 32'hFFFF_FFFF;

  file_word_buffer #(.DEPTH(8), .AW(3), .EOS_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .words_total(words_total), .done(done)
`ifdef CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [31:0] in_word;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [31:0] e_out_word;   // compared only when e_out_valid is 1
    logic [3:0]  e_count;
    logic [15:0] e_total;
    logic        e_done;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic v, input logic [31:0] w,
                              input logic r, input logic eir, input logic eov,
                              input logic [31:0] eow, input logic [3:0] ec,
                              input logic [15:0] et, input logic ed);
    vec_t x;
    x.start = s; x.in_valid = v; x.in_word = w; x.out_ready = r;
    x.e_in_ready = eir; x.e_out_valid = eov; x.e_out_word = eow;
    x.e_count = ec; x.e_total = et; x.e_done = ed;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] w, input logic r);
    start = s; in_valid = v; in_word = w; out_ready = r;
  endtask

  // One cycle: inputs already driven, take the edge, sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    string tag;
    tag = $sformatf("v%0d", i);
    check({tag, ".in_ready"},    {31'd0, in_ready},  {31'd0, x.e_in_ready});
    check({tag, ".out_valid"},   {31'd0, out_valid}, {31'd0, x.e_out_valid});
    if (x.e_out_valid) check({tag, ".out_word"}, out_word, x.e_out_word);
    check({tag, ".count"},       {28'd0, count},     {28'd0, x.e_count});
    check({tag, ".words_total"}, {16'd0, words_total}, {16'd0, x.e_total});
    check({tag, ".done"},        {31'd0, done},      {31'd0, x.e_done});
    $display("vec %0d: in_ready=%0b out_valid=%0b out_word=%h count=%0d total=%0d done=%0b",
             i, in_ready, out_valid, out_word, count, words_total, done);
  endtask

  initial begin
    //              st v  word       rdy | ir ov ow        cnt tot done
    // Stream 1,2,3 then EOS with out_ready high.
    vecs[0]  = mk(1, 0, 32'h0,      1,   1, 0, 32'h0,     0,  0, 0);
    vecs[1]  = mk(0, 1, 32'h1,      1,   1, 1, 32'h1,     1,  1, 0);
    vecs[2]  = mk(0, 1, 32'h2,      1,   1, 1, 32'h2,     1,  2, 0);
    vecs[3]  = mk(0, 1, 32'h3,      1,   1, 1, 32'h3,     1,  3, 0);
    vecs[4]  = mk(0, 1, EOS,        1,   0, 0, 32'h0,     0,  3, 0);
    vecs[5]  = mk(0, 0, 32'h0,      1,   0, 0, 32'h0,     0,  3, 1);
    // Restart, then a stream made only of the sentinel.
    vecs[6]  = mk(1, 0, 32'h0,      1,   1, 0, 32'h0,     0,  0, 0);
    vecs[7]  = mk(0, 1, EOS,        1,   0, 0, 32'h0,     0,  0, 0);
    vecs[8]  = mk(0, 0, 32'h0,      1,   0, 0, 32'h0,     0,  0, 1);
    vecs[9]  = mk(1, 0, 32'h0,      0,   1, 0, 32'h0,     0,  0, 0);
    // Fill with out_ready low: 0x10..0x17, in_ready drops after 8.
    for (int k = 0; k < 8; k++)
      vecs[10+k] = mk(0, 1, 32'h10 + 32'(k), 0, (k != 7), 1, 32'h10, 4'(k+1), 16'(k+1), 0);
    vecs[18] = mk(0, 1, 32'h18,     0,   0, 1, 32'h10,    8,  8, 0);
    // Full plus pop: pop only, then the push lands next cycle.
    vecs[19] = mk(0, 1, 32'h18,     1,   1, 1, 32'h11,    7,  8, 0);
    vecs[20] = mk(0, 1, 32'h18,     0,   0, 1, 32'h11,    8,  9, 0);
    vecs[21] = mk(0, 1, 32'h19,     1,   1, 1, 32'h12,    7,  9, 0);
    vecs[22] = mk(0, 1, 32'h19,     1,   1, 1, 32'h13,    7, 10, 0);
    // Sentinel, then drain in order 0x14..0x19.
    vecs[23] = mk(0, 1, EOS,        1,   0, 1, 32'h14,    6, 10, 0);
    for (int k = 0; k < 5; k++)
      vecs[24+k] = mk(0, 0, 32'h0, 1, 0, 1, 32'h15 + 32'(k), 4'(5-k), 10, 0);
    vecs[29] = mk(0, 0, 32'h0,      1,   0, 0, 32'h0,     0, 10, 0);
    vecs[30] = mk(0, 0, 32'h0,      1,   0, 0, 32'h0,     0, 10, 1);

    drive(0, 0, 32'h0, 0);
    rst_n = 1'b0;
    #12;
    // Reset state.
    check("rst.in_ready",    {31'd0, in_ready},  32'd0);
    check("rst.out_valid",   {31'd0, out_valid}, 32'd0);
    check("rst.out_word",    out_word,           32'd0);
    check("rst.count",       {28'd0, count},     32'd0);
    check("rst.words_total", {16'd0, words_total}, 32'd0);
    check("rst.done",        {31'd0, done},      32'd0);
`ifdef CHECKSUM_EN
    check("rst.checksum",    checksum,           32'd0);
`endif
    rst_n = 1'b1;
    tick();
    // start not yet seen: still idle.
    check("idle.in_ready", {31'd0, in_ready}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].in_valid, vecs[i].in_word, vecs[i].out_ready);
      tick();
      check_vec(i, vecs[i]);
    end

    // start ignored in STREAM: push 5 words with out_ready low, pulse start
    // in the middle, words_total must keep counting.
    drive(1, 0, 32'h0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      drive((k == 2), 1, 32'h100 + 32'(k), 0);
      tick();
    end
    drive(0, 0, 32'h0, 0);
    check("stream_start.words_total", {16'd0, words_total}, 32'd5);
    check("stream_start.count",       {28'd0, count},       32'd5);
    $display("seq start-in-stream: count=%0d total=%0d", count, words_total);

    // Asynchronous reset mid-cycle with count=5: no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count",     {28'd0, count},     32'd0);
    check("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst.done",      {31'd0, done},      32'd0);
    check("async_rst.in_ready",  {31'd0, in_ready},  32'd0);
    check("async_rst.total",     {16'd0, words_total}, 32'd0);
    $display("seq async reset: count=%0d out_valid=%0b done=%0b", count, out_valid, done);
    #3;
    rst_n = 1'b1;
    tick();

    // start ignored in DRAIN: two words, sentinel, start during drain.
    drive(1, 0, 32'h0, 0); tick();
    drive(0, 1, 32'hA, 0); tick();
    drive(0, 1, 32'hB, 0); tick();
    drive(0, 1, EOS, 0);   tick();
    drive(1, 0, 32'h0, 0); tick();
    drive(0, 0, 32'h0, 0);
    check("drain_start.in_ready", {31'd0, in_ready}, 32'd0);
    check("drain_start.total",    {16'd0, words_total}, 32'd2);
    check("drain_start.count",    {28'd0, count}, 32'd2);
    check("drain_start.head",     out_word, 32'hA);
    drive(0, 0, 32'h0, 1); tick();
    check("drain_pop.head", out_word, 32'hB);
    tick();
    check("drain_empty.done", {31'd0, done}, 32'd0);
    drive(0, 0, 32'h0, 0); tick();
    check("drain_done.done", {31'd0, done}, 32'd1);
    $display("seq start-in-drain: done=%0b total=%0d", done, words_total);

`ifdef CHECKSUM_EN
    // Checksum of 1,2,3 and of a wrapping pair.
    drive(1, 0, 32'h0, 1); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 32'(k), 1); tick();
    end
    drive(0, 1, EOS, 1); tick();
    check("cks.sum6", checksum, 32'd6);
    drive(0, 0, 32'h0, 1); tick();
    drive(1, 0, 32'h0, 1); tick();
    check("cks.cleared", checksum, 32'd0);
    drive(0, 1, 32'hFFFF_FFF0, 1); tick();
    drive(0, 1, 32'h20, 1); tick();
    drive(0, 0, 32'h0, 1);
    check("cks.wrap", checksum, 32'h10);
    $display("seq checksum: checksum=%h", checksum);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
